serial_add16: RTL and testbench
===============================

SERIAL_ADD16 -- requirements
Module: serial_add16

Interface
REQ-001 The block SHALL have no parameters; the operand width is fixed at 16 bits and the slice width at 4 bits.
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Rst  input  1  synchronous, active-high reset.
REQ-004 Start  input  1  request to begin a 16-bit add; sampled on the rising edge of Clk.
REQ-005 X  input  16  operand A; captured when Start is accepted.
REQ-006 Y  input  16  operand B; captured when Start is accepted.
REQ-007 Cin  input  1  carry-in; captured when Start is accepted.
REQ-008 SliceX  output  4  nibble of A driven to the external 4-bit adder slice.
REQ-009 SliceY  output  4  nibble of B driven to the external 4-bit adder slice.
REQ-010 SliceCin  output  1  carry driven to the slice.
REQ-011 SliceSum  input  4  combinational sum returned by the slice.
REQ-012 SliceCout  input  1  combinational carry-out returned by the slice.
REQ-013 Busy  output  1  high in the RUN state.
REQ-014 Done  output  1  one-cycle pulse that marks valid Sum, Cout and Ovf.
REQ-015 Sum  output  16  registered 16-bit result.
REQ-016 Cout  output  1  registered carry-out of bit 15.
REQ-017 Ovf  output  1  registered two's-complement overflow flag.

Function
REQ-018 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-019 In IDLE or DONE, Start=1 at an edge SHALL trigger all of the following:
- latch X and Y into the internal registers A and B;
- set the carry register to Cin;
- set the 2-bit nibble index k to 0;
- enter RUN.
REQ-020 In RUN, Start SHALL be ignored, and X, Y and Cin SHALL have no effect.
REQ-021 In RUN, the slice outputs SHALL be driven combinationally from the registers:
- SliceX = A[4k+3:4k];
- SliceY = B[4k+3:4k];
- SliceCin = the carry register.
REQ-022 At each RUN edge, the block SHALL:
- store SliceSum into partial[4k+3:4k];
- load SliceCout into the carry register;
- increment k.
REQ-023 At the RUN edge where k=3, the block SHALL:
- load Sum with {SliceSum, partial[11:0]};
- load Cout with SliceCout;
- load Ovf with (A[15]==B[15]) && (SliceSum[3]!=A[15]);
- enter DONE.
REQ-024 Done SHALL be 1 only in DONE, and DONE SHALL last exactly one cycle before returning to IDLE, or to RUN if Start=1.
REQ-025 Latency SHALL be fixed: if Start is accepted at edge N, RUN captures nibbles 0..3 at edges N+1..N+4, and Done is high in the cycle following edge N+4.
REQ-026 The minimum accepted-Start-to-accepted-Start period SHALL be 5 cycles, with Start held high through DONE.
REQ-027 Sum, Cout and Ovf SHALL change only at the final RUN edge or on reset, and SHALL hold their values through the following operation until its final edge.
REQ-028 Outside RUN, SliceX, SliceY and SliceCin SHALL be 0.
REQ-029 Busy SHALL be 1 exactly in RUN, i.e. for 4 cycles per operation.
REQ-030 Carry propagation SHALL be modulo 2^16: the carry out of bit 15 appears only on Cout and never wraps into Sum.

Reset
REQ-031 Rst=1 at an edge SHALL force the following, overriding Start:
- state IDLE;
- k=0;
- carry register 0;
- A, B and partial all 0;
- outputs Busy=0, Done=0, Sum=0x0000, Cout=0, Ovf=0.
REQ-032 Rst during RUN or DONE SHALL abort the operation; no Done pulse SHALL follow for the aborted operation.
REQ-033 Rst SHALL take effect only at a Clk edge; its assertion between edges SHALL change no output.

Verification
REQ-034 X=0x1234, Y=0x4321, Cin=0, Start at edge N -> Busy for 4 cycles, Done in the cycle after N+4, Sum=0x5555, Cout=0, Ovf=0.
REQ-035 X=0xFFFF, Y=0x0001, Cin=0 -> SliceCin observed as 0,1,1,1 across the RUN cycles; result Sum=0x0000, Cout=1, Ovf=0.
REQ-036 X=0x7FFF, Y=0x0000, Cin=1 -> Sum=0x8000, Cout=0, Ovf=1; X=0x8000, Y=0x8000, Cin=0 -> Sum=0x0000, Cout=1, Ovf=1.
REQ-037 Start is pulsed again in the 2nd RUN cycle with X=0xAAAA -> the pulse is ignored; the result is that of the first operands; a single Done pulse; Sum unchanged until the final edge.
REQ-038 Rst=1 in the 2nd RUN cycle -> next cycle all outputs are 0 and the state is IDLE; no Done within 10 cycles without a new Start.
REQ-039 Start held high for three operations (0x0001+0x0001, 0x00FF+0x0001, 0xFFFF+0xFFFF with Cin=1) -> Done every 5 cycles, with results in order:
- 0x0002, Cout=0;
- 0x0100, Cout=0;
- 0xFFFF, Cout=1.

Source files
------------

// File: rtl/serial_add16.sv
// Serial 16-bit adder that time-shares an external 4-bit adder slice,
// feeding it one nibble per cycle from least to most significant.
module serial_add16 (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [15:0] X,
    input  logic [15:0] Y,
    input  logic        Cin,
    output logic [3:0]  SliceX,
    output logic [3:0]  SliceY,
    output logic        SliceCin,
    input  logic [3:0]  SliceSum,
    input  logic        SliceCout,
    output logic        Busy,
    output logic        Done,
    output logic [15:0] Sum,
    output logic        Cout,
    output logic        Ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic        carry_q, carry_d;
    logic [1:0]  k_q, k_d;
    logic [15:0] partial_q, partial_d;
    logic [15:0] sum_q, sum_d;
    logic        cout_q, cout_d;
    logic        ovf_q, ovf_d;
    logic [3:0]  nibBase;

    assign nibBase = {k_q, 2'b00};

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= IDLE;
            a_q       <= 16'h0000;
            b_q       <= 16'h0000;
            carry_q   <= 1'b0;
            k_q       <= 2'd0;
            partial_q <= 16'h0000;
            sum_q     <= 16'h0000;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            carry_q   <= carry_d;
            k_q       <= k_d;
            partial_q <= partial_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
        end
    end

    // The slice sees only the current nibble while running; outside RUN it is driven to 0.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        carry_d   = carry_q;
        k_d       = k_q;
        partial_d = partial_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        SliceX    = 4'h0;
        SliceY    = 4'h0;
        SliceCin  = 1'b0;
        Busy      = 1'b0;
        Done      = 1'b0;

        case (state_q)
            RUN: begin
                Busy      = 1'b1;
                SliceX    = a_q[nibBase +: 4];
                SliceY    = b_q[nibBase +: 4];
                SliceCin  = carry_q;
                partial_d[nibBase +: 4] = SliceSum;
                carry_d   = SliceCout;
                k_d       = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    sum_d   = {SliceSum, partial_q[11:0]};
                    cout_d  = SliceCout;
                    ovf_d   = (a_q[15] == b_q[15]) && (SliceSum[3] != a_q[15]);
                    state_d = DONE;
                end
            end
            default: begin
                Done = (state_q == DONE);
                if (Start) begin
                    a_d     = X;
                    b_d     = Y;
                    carry_d = Cin;
                    k_d     = 2'd0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    assign Sum  = sum_q;
    assign Cout = cout_q;
    assign Ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add16.sv
// Bench for serial_add16: directed operations with literal expectations,
// plus a per-cycle comparison against an arithmetic reference model.
module tb_serial_add16;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] x;
    logic [15:0] y;
    logic        cin;
    logic [3:0]  sliceX;
    logic [3:0]  sliceY;
    logic        sliceCin;
    logic [3:0]  sliceSum;
    logic        sliceCout;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    serial_add16 dut (
        .Clk       (clk),
        .Rst       (rst),
        .Start     (start),
        .X         (x),
        .Y         (y),
        .Cin       (cin),
        .SliceX    (sliceX),
        .SliceY    (sliceY),
        .SliceCin  (sliceCin),
        .SliceSum  (sliceSum),
        .SliceCout (sliceCout),
        .Busy      (busy),
        .Done      (done),
        .Sum       (sum),
        .Cout      (cout),
        .Ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External 4-bit adder slice.
    assign {sliceCout, sliceSum} = {1'b0, sliceX} + {1'b0, sliceY} + {4'b0000, sliceCin};

    // Reference model: phase counts cycles since an accepted Start (0 = idle, 1..4 = busy, 5 = done).
    int          phase     = 0;
    logic        modelLive = 1'b0;
    logic [15:0] mA = 16'h0000;
    logic [15:0] mB = 16'h0000;
    logic        mC = 1'b0;
    logic [15:0] mSum = 16'h0000;
    logic        mCout = 1'b0;
    logic        mOvf = 1'b0;
    logic [16:0] mTotal;

    assign mTotal = {1'b0, mA} + {1'b0, mB} + {16'h0000, mC};

    always @(posedge clk) begin
        if (rst) begin
            modelLive <= 1'b1;
            phase     <= 0;
            mA        <= 16'h0000;
            mB        <= 16'h0000;
            mC        <= 1'b0;
            mSum      <= 16'h0000;
            mCout     <= 1'b0;
            mOvf      <= 1'b0;
        end else if ((phase == 0 || phase == 5) && start) begin
            mA    <= x;
            mB    <= y;
            mC    <= cin;
            phase <= 1;
        end else if (phase >= 1 && phase <= 4) begin
            phase <= phase + 1;
            if (phase == 4) begin
                mSum  <= mTotal[15:0];
                mCout <= mTotal[16];
                mOvf  <= (mA[15] == mB[15]) && (mTotal[15] != mA[15]);
            end
        end else begin
            phase <= 0;
        end
    end

    logic [3:0]  expSliceX;
    logic [3:0]  expSliceY;
    logic        expSliceCin;
    logic [16:0] lowMask;
    logic [16:0] lowSum;

    // Carry into nibble n is the carry out of adding the low 4n bits of both operands plus Cin.
    always_comb begin
        expSliceX   = 4'h0;
        expSliceY   = 4'h0;
        expSliceCin = 1'b0;
        lowMask     = 17'h0;
        lowSum      = 17'h0;
        if (phase >= 1 && phase <= 4) begin
            expSliceX   = 4'((mA >> (4 * (phase - 1))) & 16'h000F);
            expSliceY   = 4'((mB >> (4 * (phase - 1))) & 16'h000F);
            lowMask     = (17'h1 << (4 * (phase - 1))) - 17'h1;
            lowSum      = ({1'b0, mA} & lowMask) + ({1'b0, mB} & lowMask) + {16'h0000, mC};
            expSliceCin = lowSum[4 * (phase - 1)];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (modelLive) begin
            checkOutput("model_busy", busy, (phase >= 1 && phase <= 4));
            checkOutput("model_done", done, (phase == 5));
            checkOutput("model_sum", sum, mSum);
            checkOutput("model_cout", cout, mCout);
            checkOutput("model_ovf", ovf, mOvf);
            checkOutput("model_slicex", sliceX, expSliceX);
            checkOutput("model_slicey", sliceY, expSliceY);
            checkOutput("model_slicecin", sliceCin, expSliceCin);
        end
    end

    // One full operation with a one-cycle Start pulse; returns SliceCin per RUN cycle.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic c,
                                 input logic [15:0] eSum, input logic eCout, input logic eOvf,
                                 input string name, output logic [3:0] cinSeq);
        @(negedge clk);
        start = 1'b1;
        x     = a;
        y     = b;
        cin   = c;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput({name, "_busy"}, busy, 1);
            checkOutput({name, "_nodone"}, done, 0);
            cinSeq[i] = sliceCin;
            @(negedge clk);
        end
        checkOutput({name, "_done"}, done, 1);
        checkOutput({name, "_busy_off"}, busy, 0);
        checkOutput({name, "_sum"}, sum, eSum);
        checkOutput({name, "_cout"}, cout, eCout);
        checkOutput({name, "_ovf"}, ovf, eOvf);
    endtask

    logic [15:0] bxs [3] = '{16'h0001, 16'h00FF, 16'hFFFF};
    logic [15:0] bys [3] = '{16'h0001, 16'h0001, 16'hFFFF};
    logic        bcs [3] = '{1'b0, 1'b0, 1'b1};
    logic [15:0] bes [3] = '{16'h0002, 16'h0100, 16'hFFFF};
    logic        bec [3] = '{1'b0, 1'b0, 1'b1};

    initial begin
        logic [3:0] seq;
        rst   = 1'b1;
        start = 1'b0;
        x     = 16'h0000;
        y     = 16'h0000;
        cin   = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_sum", sum, 16'h0000);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_slicex", sliceX, 0);
        rst = 1'b0;

        applyStimulus(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, "basic", seq);
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "ripple", seq);
        checkOutput("ripple_slicecin_seq", seq, 4'b1110);
        applyStimulus(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "neg_ovf", seq);
        applyStimulus(16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1, "pos_ovf", seq);

        // Start re-pulsed mid-operation must be ignored.
        @(negedge clk);
        start = 1'b1; x = 16'h1357; y = 16'h2468; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        checkOutput("ignore_sum_hold1", sum, 16'h8000);
        @(negedge clk);
        start = 1'b1; x = 16'hAAAA; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("ignore_busy3", busy, 1);
        @(negedge clk);
        checkOutput("ignore_sum_hold4", sum, 16'h8000);
        @(negedge clk);
        checkOutput("ignore_done", done, 1);
        checkOutput("ignore_sum", sum, 16'h37BF);
        @(negedge clk);
        checkOutput("ignore_single_done", done, 0);
        checkOutput("ignore_idle", busy, 0);

        // Reset in the second RUN cycle aborts the operation.
        @(negedge clk);
        start = 1'b1; x = 16'h1111; y = 16'h2222; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_sum", sum, 16'h0000);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_slicex", sliceX, 0);
        for (int i = 0; i < 10; i++) begin
            checkOutput("abort_no_done", done, 0);
            @(negedge clk);
        end

        // Start held high: back-to-back operations every 5 cycles.
        start = 1'b1; x = bxs[0]; y = bys[0]; cin = bcs[0];
        for (int j = 0; j < 3; j++) begin
            repeat (5) @(negedge clk);
            checkOutput("b2b_done", done, 1);
            checkOutput("b2b_sum", sum, bes[j]);
            checkOutput("b2b_cout", cout, bec[j]);
            checkOutput("b2b_ovf", ovf, 0);
            if (j < 2) begin
                x = bxs[j + 1]; y = bys[j + 1]; cin = bcs[j + 1];
            end else begin
                start = 1'b0;
            end
        end
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
